adc_cic_filter: RTL and testbench

Decimating filter stage directly downstream of the ADC bitstream buffer. On each `buffer_full` strobe it captures the four 32-bit sigma-delta words, converts each to a sinc1 sample (popcount, decimate-by-32), then runs a 2nd-order CIC (decimate-by-2^DEC_LOG2) per channel on a shared, time-multiplexed datapath. It publishes one 4-channel result set with a valid/ack handshake toward the Wishbone-side register/blockram logic.

---
 rtl/adc_filter_pkg.sv | 21 ++
 rtl/adc_cic_filter_popcount32.sv | 12 +
 rtl/adc_cic_filter.sv | 138 +++++++++++++
 tb/tb_adc_cic_filter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_filter_pkg.sv
// adc_filter_pkg: shared constants and FSM state type for the ADC CIC filter.
package adc_filter_pkg;
   localparam int NUM_CH       = 4;
   localparam int WORD_W       = 32;
   localparam int POP_W        = 6;
   localparam int DEC_LOG2_DEF = 3;

   function automatic int out_w(input int dec_log2);
      return POP_W + 2 * dec_log2;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_POP,
      ST_CH0,
      ST_CH1,
      ST_CH2,
      ST_CH3
   } state_t;
endpackage

// File: rtl/adc_cic_filter_popcount32.sv
// popcount32: combinational ones count of a 32-bit sigma-delta word (sinc1, decimate-by-32).
module popcount32
   import adc_filter_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   output logic [POP_W-1:0]  o_count
);
   always_comb begin
      o_count = '0;
      for (int i = 0; i < WORD_W; i++) o_count = o_count + POP_W'(i_word[i]);
   end
endmodule

// File: rtl/adc_cic_filter.sv
// adc_cic_filter: sinc1 popcount front end plus a time-multiplexed 2nd-order CIC
// across four channels, publishing one result set per D strobes with valid/ack.
module adc_cic_filter
   import adc_filter_pkg::*;
#(
   parameter int DEC_LOG2 = DEC_LOG2_DEF,
   parameter int OUT_W    = out_w(DEC_LOG2)
) (
   input  logic              adc_clk_i,
   input  logic              reset,
   input  logic              buffer_full_i,
   input  logic [WORD_W-1:0] adc_a_buf_i,
   input  logic [WORD_W-1:0] adc_b_buf_i,
   input  logic [WORD_W-1:0] adc_c_buf_i,
   input  logic [WORD_W-1:0] adc_d_buf_i,
   output logic [OUT_W-1:0]  sample_a_o,
   output logic [OUT_W-1:0]  sample_b_o,
   output logic [OUT_W-1:0]  sample_c_o,
   output logic [OUT_W-1:0]  sample_d_o,
   output logic              sample_valid_o,
   input  logic              sample_ack_i,
   output logic              busy_o,
   output logic              overrun_o
);
   state_t              r_state, w_next;
   logic [WORD_W-1:0]   w_buf [NUM_CH];
   logic [WORD_W-1:0]   r_word [NUM_CH];
   logic [POP_W-1:0]    w_pop [NUM_CH];
   logic [POP_W-1:0]    r_pop [NUM_CH];
   logic [OUT_W-1:0]    r_int1 [NUM_CH];
   logic [OUT_W-1:0]    r_int2 [NUM_CH];
   logic [OUT_W-1:0]    r_int2_prev [NUM_CH];
   logic [OUT_W-1:0]    r_c1_prev [NUM_CH];
   logic [OUT_W-1:0]    r_stage [NUM_CH];
   logic [OUT_W-1:0]    r_sample [NUM_CH];
   logic [1:0]          r_ch;
   logic [DEC_LOG2-1:0] r_dec_ctr;
   logic                r_valid, r_overrun;
   logic [OUT_W-1:0]    w_int1, w_int2, w_c1, w_y;
   logic                w_proc, w_last, w_publish, w_accept;

   always_comb begin
      w_buf[0] = adc_a_buf_i;
      w_buf[1] = adc_b_buf_i;
      w_buf[2] = adc_c_buf_i;
      w_buf[3] = adc_d_buf_i;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pop
      popcount32 u_pop (.i_word(r_word[g]), .o_count(w_pop[g]));
   end

   always_ff @(posedge adc_clk_i or negedge reset)
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;

   // Illegal encodings wrap through the increment back to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: w_next = buffer_full_i ? ST_CAPTURE : ST_IDLE;
         ST_CH3:  w_next = ST_IDLE;
         default: w_next = state_t'(r_state + 3'd1);
      endcase
   end

   assign w_accept  = (r_state == ST_IDLE) && buffer_full_i;
   assign w_proc    = r_state inside {ST_CH0, ST_CH1, ST_CH2, ST_CH3};
   assign w_last    = (r_dec_ctr == '1);
   assign w_publish = (r_state == ST_CH3) && w_last;
   assign w_int1    = r_int1[r_ch] + OUT_W'(r_pop[r_ch]);
   assign w_int2    = r_int2[r_ch] + w_int1;
   assign w_c1      = w_int2 - r_int2_prev[r_ch];
   assign w_y       = w_c1 - r_c1_prev[r_ch];

   always_ff @(posedge adc_clk_i or negedge reset)
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_word[i] <= '0;
            r_pop[i]  <= '0;
         end
      end else begin
         if (w_accept) for (int i = 0; i < NUM_CH; i++) r_word[i] <= w_buf[i];
         if (r_state == ST_CAPTURE) for (int i = 0; i < NUM_CH; i++) r_pop[i] <= w_pop[i];
      end

   // One channel per cycle; comb history only advances on the decimation boundary.
   always_ff @(posedge adc_clk_i or negedge reset)
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_int1[i]      <= '0;
            r_int2[i]      <= '0;
            r_int2_prev[i] <= '0;
            r_c1_prev[i]   <= '0;
            r_stage[i]     <= '0;
         end
         r_ch      <= '0;
         r_dec_ctr <= '0;
      end else begin
         if (r_state == ST_POP) r_ch <= '0;
         if (w_proc) begin
            r_ch         <= r_ch + 2'd1;
            r_int1[r_ch] <= w_int1;
            r_int2[r_ch] <= w_int2;
            if (w_last) begin
               r_int2_prev[r_ch] <= w_int2;
               r_c1_prev[r_ch]   <= w_c1;
               r_stage[r_ch]     <= w_y;
            end
         end
         if (r_state == ST_CH3) r_dec_ctr <= r_dec_ctr + 1'b1;
      end

   always_ff @(posedge adc_clk_i or negedge reset)
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) r_sample[i] <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_publish) begin
            r_sample[0] <= r_stage[0];
            r_sample[1] <= r_stage[1];
            r_sample[2] <= r_stage[2];
            r_sample[3] <= w_y;
         end
         r_valid <= w_publish | (r_valid & ~sample_ack_i);
         if ((w_publish && r_valid && !sample_ack_i) || (buffer_full_i && r_state != ST_IDLE))
            r_overrun <= 1'b1;
      end

   assign sample_a_o     = r_sample[0];
   assign sample_b_o     = r_sample[1];
   assign sample_c_o     = r_sample[2];
   assign sample_d_o     = r_sample[3];
   assign sample_valid_o = r_valid;
   assign overrun_o      = r_overrun;
   assign busy_o         = (r_state != ST_IDLE);
endmodule

// File: tb/tb_adc_cic_filter.sv
// tb_adc_cic_filter: scoreboard bench; a double-sum reference model predicts each
// sequence's outputs, checked when busy_o drops. A second DEC_LOG2=6 instance runs alongside.
module tb_adc_cic_filter;
   localparam int OW  = 12;
   localparam int D   = 8;
   localparam int OW6 = 18;

   typedef struct packed {
      logic          pub;
      logic [4*OW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n, bf, ack, auto_ack;
   logic [31:0] wa, wb, wc, wd;
   logic [OW-1:0] sa, sb, sc, sd;
   logic valid, busy, ovr;
   logic rst6_n, bf6, ack6, done6;
   logic [OW6-1:0] s6a, s6b, s6c, s6d;
   logic valid6, busy6, ovr6;
   logic [31:0] ones = 32'hFFFF_FFFF;

   int n_tests = 0, n_fail = 0;
   int s1[4], s2[4], b1[4], b2[4], cnt;
   logic [OW-1:0] last_exp[4];
   exp_t q[$];
   exp_t me;
   logic prev_busy = 1'b0;
   logic [4*OW-1:0] obs;
   int pub6 = 0;
   logic prev_v6 = 1'b0;

   adc_cic_filter u_dut (
      .adc_clk_i(clk), .reset(rst_n), .buffer_full_i(bf),
      .adc_a_buf_i(wa), .adc_b_buf_i(wb), .adc_c_buf_i(wc), .adc_d_buf_i(wd),
      .sample_a_o(sa), .sample_b_o(sb), .sample_c_o(sc), .sample_d_o(sd),
      .sample_valid_o(valid), .sample_ack_i(ack), .busy_o(busy), .overrun_o(ovr)
   );

   adc_cic_filter #(.DEC_LOG2(6)) u_dut6 (
      .adc_clk_i(clk), .reset(rst6_n), .buffer_full_i(bf6),
      .adc_a_buf_i(ones), .adc_b_buf_i(ones), .adc_c_buf_i(ones), .adc_d_buf_i(ones),
      .sample_a_o(s6a), .sample_b_o(s6b), .sample_c_o(s6c), .sample_d_o(s6d),
      .sample_valid_o(valid6), .sample_ack_i(ack6), .busy_o(busy6), .overrun_o(ovr6)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      for (int ch = 0; ch < 4; ch++) begin
         s1[ch] = 0; s2[ch] = 0; b1[ch] = 0; b2[ch] = 0; last_exp[ch] = '0;
      end
      cnt = 0;
      q.delete();
   endtask

   // Output on a boundary is the second difference of the double running sum.
   task automatic model_push(input logic [31:0] a, b, c, d);
      logic [31:0] w[4];
      exp_t e;
      int y;
      w = '{a, b, c, d};
      cnt++;
      e.pub = (cnt % D == 0);
      for (int ch = 0; ch < 4; ch++) begin
         s1[ch] += $countones(w[ch]);
         s2[ch] += s1[ch];
         if (e.pub) begin
            y = s2[ch] - 2 * b1[ch] + b2[ch];
            b2[ch] = b1[ch];
            b1[ch] = s2[ch];
            last_exp[ch] = OW'(y);
         end
         e.data[ch*OW +: OW] = last_exp[ch];
      end
      q.push_back(e);
   endtask

   task automatic strobe(input logic [31:0] a, b, c, d, input bit ack_pub = 0, input bit extra = 0);
      model_push(a, b, c, d);
      @(posedge clk); #1;
      bf = 1; wa = a; wb = b; wc = c; wd = d;
      @(posedge clk); #1;
      bf = 0;
      if (extra) begin
         repeat (2) @(posedge clk);
         #1 bf = 1; wa = ~a; wb = ~b; wc = ~c; wd = ~d;
         @(posedge clk); #1 bf = 0;
      end
      if (ack_pub) begin
         repeat (5) @(posedge clk);
         #1 ack = 1;
         @(posedge clk); #1 ack = 0;
      end
      repeat (26) @(posedge clk);
   endtask

   always @(negedge clk) begin
      obs = {sd, sc, sb, sa};
      if (rst_n && prev_busy && !busy) begin
         if (q.size() == 0) chk("sb_underflow", 32'(q.size()), 1);
         else begin
            me = q.pop_front();
            for (int ch = 0; ch < 4; ch++)
               chk($sformatf("out_ch%0d", ch), 32'(obs[ch*OW +: OW]), 32'(me.data[ch*OW +: OW]));
            if (me.pub) chk("pub_valid", 32'(valid), 1);
         end
      end
      prev_busy = busy;
      if (auto_ack) ack = valid & ~ack;
   end

   always @(negedge clk) begin
      if (rst6_n && valid6 && !prev_v6) begin
         pub6++;
         chk("d6_a", 32'(s6a), pub6 == 1 ? 66560 : 131072);
         chk("d6_b", 32'(s6b), pub6 == 1 ? 66560 : 131072);
         chk("d6_c", 32'(s6c), pub6 == 1 ? 66560 : 131072);
         chk("d6_d", 32'(s6d), pub6 == 1 ? 66560 : 131072);
      end
      prev_v6 = valid6;
      ack6 = valid6 & ~ack6;
   end

   initial begin
      rst6_n = 1; bf6 = 0; ack6 = 0; done6 = 0;
      #3 rst6_n = 0;
      repeat (3) @(posedge clk);
      #1 rst6_n = 1;
      for (int k = 0; k < 130; k++) begin
         @(posedge clk); #1 bf6 = 1;
         @(posedge clk); #1 bf6 = 0;
         repeat (30) @(posedge clk);
      end
      done6 = 1;
   end

   initial begin
      auto_ack = 1; ack = 0; bf = 0; wa = '0; wb = '0; wc = '0; wd = '0;
      rst_n = 1;
      #3 rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a", 32'(sa), 0);
      chk("rst_b", 32'(sb), 0);
      chk("rst_c", 32'(sc), 0);
      chk("rst_d", 32'(sd), 0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovr", 32'(ovr), 0);
      rst_n = 1;

      for (int i = 0; i < 24; i++) strobe(ones, ones, ones, ones);
      chk("ones_a", 32'(sa), 2048);
      chk("ones_d", 32'(sd), 2048);
      chk("ones_ovr", 32'(ovr), 0);

      // Abort a sequence at E3 with reset.
      @(posedge clk); #1 bf = 1;
      @(posedge clk); #1 bf = 0;
      chk("busy_hi", 32'(busy), 1);
      repeat (3) @(posedge clk);
      #1 rst_n = 0;
      model_reset();
      #2;
      chk("mid_a", 32'(sa), 0);
      chk("mid_d", 32'(sd), 0);
      chk("mid_valid", 32'(valid), 0);
      chk("mid_busy", 32'(busy), 0);
      @(posedge clk); #1 rst_n = 1;

      for (int i = 0; i < 24; i++) strobe(32'h0, 32'h5555_5555, 32'hFFFF_0000, 32'h1);
      chk("pat_a", 32'(sa), 0);
      chk("pat_b", 32'(sb), 1024);
      chk("pat_c", 32'(sc), 1024);
      chk("pat_d", 32'(sd), 64);

      for (int i = 0; i < 16; i++) strobe($urandom, $urandom, $urandom, $urandom);

      auto_ack = 0;
      @(posedge clk); #1 ack = 0;
      for (int i = 0; i < 8; i++) strobe(32'h00FF_00FF, 32'h7, 32'hFFFF_FFFE, 32'h8000_0000);
      chk("noack_valid", 32'(valid), 1);
      chk("noack_ovr", 32'(ovr), 0);
      for (int i = 0; i < 8; i++) strobe(32'h0F0F_0F0F, 32'h3, 32'hFFFF_FFFF, 32'h0, i == 7);
      chk("sameack_valid", 32'(valid), 1);
      chk("sameack_ovr", 32'(ovr), 0);
      for (int i = 0; i < 8; i++) strobe(32'hFFFF_FFFF, 32'h0, 32'h0000_FFFF, 32'hAAAA_AAAA);
      chk("overrun_set", 32'(ovr), 1);
      chk("overrun_valid", 32'(valid), 1);
      @(posedge clk); #1 ack = 1;
      @(posedge clk); #1 ack = 0;
      chk("ack_clear", 32'(valid), 0);
      ack = 1;
      @(posedge clk); #1 ack = 0;
      chk("ack_idle", 32'(valid), 0);

      rst_n = 0;
      model_reset();
      @(posedge clk); #1 rst_n = 1;
      auto_ack = 1;
      chk("ovr_cleared", 32'(ovr), 0);
      strobe(32'h1, 32'h3, 32'h7, 32'hF, 0, 1);
      chk("extra_ovr", 32'(ovr), 1);
      for (int i = 0; i < 7; i++) strobe(32'h1, 32'h3, 32'h7, 32'hF);
      chk("extra_a", 32'(sa), 36);
      chk("extra_d", 32'(sd), 144);
      chk("sb_drain", 32'(q.size()), 0);

      for (int i = 0; i < 20000 && !done6; i++) @(posedge clk);
      chk("d6_done", 32'(done6), 1);
      chk("d6_pubs", 32'(pub6), 2);
      chk("d6_ovr", 32'(ovr6), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
